bubble_loop_counter: RTL



---
 rtl/bubble_loop_pkg.sv | 18 +
 rtl/counter_ld.sv | 39 +++
 rtl/bubble_loop_counter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/bubble_loop_pkg.sv
// Shared types and constants for the bubble-sort loop index generator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   DEFAULT_WIDTH : default bit width of LEN and the I/J indices
//   state_t       : sequencer state (IDLE, RUN, FIN)
package bubble_loop_pkg;

  localparam int DEFAULT_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/counter_ld.sv
// Loadable up-counter used for the pass index I and the compare index J.
// Latency: q updates one cycle after clr/load/en.
// Backpressure: none; en simply holds the count when low.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, q -> 0
//   clr   : synchronous clear, highest priority after reset
//   load  : synchronous load of p_in, beats en
//   en    : increment by one
//   p_in  : load value
//   q     : current count
module counter_ld
  import bubble_loop_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] p_in,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= p_in;
    end else if (en) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/bubble_loop_counter.sv
// Nested-loop (I,J) compare-position generator for the bubble-sort controller.
// Latency: indices move the cycle after an accepted step; done pulses the cycle after the final step.
// Backpressure: step low holds all state; start while busy and step outside RUN are ignored.
//
// Optional feature: define BUBBLE_LOOP_EARLY_EXIT_EN to add the no_swap input,
// which ends the run at the end of any pass in which no swap happened.
//
// Ports:
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   start    : begin a run (accepted only in IDLE)
//   len      : array length, latched on an accepted start
//   step     : advance to the next compare position (honoured only in RUN)
//   clr      : synchronous abort to IDLE, beats start and step
//   no_swap  : (early-exit build only) no swap in the pass being completed
//   busy     : high in RUN and FIN
//   i_idx    : current pass index
//   j_idx    : current compare index (pair j, j+1)
//   j_last   : combinational, j_idx is the last compare of this pass
//   pass_end : one-cycle pulse after the step that completed a pass
//   done     : one-cycle pulse, run complete
module bubble_loop_counter
  import bubble_loop_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] len,
  input  logic             step,
  input  logic             clr,
`ifdef BUBBLE_LOOP_EARLY_EXIT_EN
  input  logic             no_swap,
`endif
  output logic             busy,
  output logic [WIDTH-1:0] i_idx,
  output logic [WIDTH-1:0] j_idx,
  output logic             j_last,
  output logic             pass_end,
  output logic             done
);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] len_q;

  // Limits are kept one bit wider so len_q-2 cannot alias when len_q < 2;
  // in RUN len_q >= 2 and i_idx <= len_q-2, so the real values never go negative.
  logic [WIDTH:0]   j_limit;
  logic [WIDTH:0]   i_limit;

  logic             short_len;
  logic             start_acc;
  logic             step_acc;
  logic             pass_done;
  logic             early_exit;
  logic             final_pass;

  logic             idx_clr;
  logic             i_en;
  logic             j_en;
  logic             j_load;

  // ------------------------------------------------------------------
  // Limit compare and handshake qualification
  // ------------------------------------------------------------------
  always_comb begin
    i_limit    = {1'b0, len_q} - (WIDTH+1)'(2);
    j_limit    = i_limit - {1'b0, i_idx};
    j_last     = (state_q == RUN) && ({1'b0, j_idx} == j_limit);

    short_len  = ({1'b0, len} < (WIDTH+1)'(2));
    start_acc  = (state_q == IDLE) && start && !clr;
    step_acc   = (state_q == RUN) && step && !clr;
    pass_done  = step_acc && j_last;

`ifdef BUBBLE_LOOP_EARLY_EXIT_EN
    early_exit = no_swap;
`else
    early_exit = 1'b0;
`endif
    final_pass = ({1'b0, i_idx} == i_limit) || early_exit;
  end

  // ------------------------------------------------------------------
  // FSM: next state
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_acc) begin
          state_d = short_len ? FIN : RUN;
        end
      end
      RUN: begin
        if (pass_done && final_pass) begin
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (clr) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ------------------------------------------------------------------
  // Index counter controls
  // ------------------------------------------------------------------
  always_comb begin
    // Indices return to zero on abort, on a new run and when leaving FIN;
    // on the final pass they hold so the last compare position stays visible in FIN.
    idx_clr = clr || start_acc || (state_q == FIN);
    i_en    = pass_done && !final_pass;
    j_load  = pass_done && !final_pass;
    j_en    = step_acc && !j_last;
  end

  counter_ld #(
    .WIDTH (WIDTH)
  ) u_i_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (idx_clr),
    .load  (1'b0),
    .en    (i_en),
    .p_in  ('0),
    .q     (i_idx)
  );

  // J restarts each pass by loading zero.
  counter_ld #(
    .WIDTH (WIDTH)
  ) u_j_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (idx_clr),
    .load  (j_load),
    .en    (j_en),
    .p_in  ('0),
    .q     (j_idx)
  );

  // ------------------------------------------------------------------
  // Length latch and output pulses
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q    <= '0;
      pass_end <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (start_acc) begin
        len_q <= len;
      end
      pass_end <= pass_done;
      // FIN lasts exactly one cycle, so flagging entry into FIN gives a single pulse.
      done     <= (state_d == FIN) && (state_q != FIN);
    end
  end

  assign busy = (state_q != IDLE);

endmodule
